// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format codes, error codes, FSM encoding and the reference decoder.
package imm_encoder_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SRC_W = 3;
  localparam int unsigned ERR_CW = 2;

  typedef logic [SRC_W-1:0]  imm_src_t;
  typedef logic [ERR_CW-1:0] enc_err_t;

  // Same codes the Sign_Extend decoder uses
  localparam imm_src_t SRC_I = 3'b000;
  localparam imm_src_t SRC_S = 3'b001;
  localparam imm_src_t SRC_B = 3'b010;
  localparam imm_src_t SRC_J = 3'b011;
  localparam imm_src_t SRC_U = 3'b100;

  localparam enc_err_t ERR_OK    = 2'b00;
  localparam enc_err_t ERR_RANGE = 2'b01;
  localparam enc_err_t ERR_SRC   = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    enc_err_t        err;
  } enc_res_t;

  // Inverse of the packer: recover the immediate an instruction carries
  function automatic logic [XLEN-1:0] sign_extend(input logic [XLEN-1:0] i, input imm_src_t src);
    case (src)
      SRC_I:   sign_extend = {{20{i[31]}}, i[31:20]};
      SRC_S:   sign_extend = {{20{i[31]}}, i[31:25], i[11:7]};
      SRC_B:   sign_extend = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      SRC_J:   sign_extend = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      SRC_U:   sign_extend = {i[31:12], 12'h000};
      default: sign_extend = '0;
    endcase
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle for the immediate encoder.
interface imm_encoder_if;
  import imm_encoder_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] imm;
  imm_src_t        imm_src;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  enc_err_t        out_err;

  modport slave (
    input  in_valid, base, imm, imm_src, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

  modport master (
    output in_valid, base, imm, imm_src, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );
endinterface

// File: rtl/imm_encoder_imm_pack.sv
// Combinational immediate packer with representability check.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] imm,
  input  imm_src_t        imm_src,
  output enc_res_t        res
);

  logic eq_31_11;
  logic eq_31_12;
  logic eq_31_20;

  // Upper bits must be a pure sign extension of the encodable field
  always_comb begin
    eq_31_11 = (&imm[31:11]) | ~(|imm[31:11]);
    eq_31_12 = (&imm[31:12]) | ~(|imm[31:12]);
    eq_31_20 = (&imm[31:20]) | ~(|imm[31:20]);
  end

  // Scatter immediate bits into the format's slots; err flags a truncated packing
  always_comb begin
    res.instr = base;
    res.err   = ERR_OK;
    case (imm_src)
      SRC_I: begin
        res.instr = {imm[11:0], base[19:0]};
        if (!eq_31_11) res.err = ERR_RANGE;
      end
      SRC_S: begin
        res.instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        if (!eq_31_11) res.err = ERR_RANGE;
      end
      SRC_B: begin
        res.instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        if (!eq_31_12 || imm[0]) res.err = ERR_RANGE;
      end
      SRC_J: begin
        res.instr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        if (!eq_31_20 || imm[0]) res.err = ERR_RANGE;
      end
      SRC_U: begin
        res.instr = {imm[31:12], base[11:0]};
        if (imm[11:0] != 12'h000) res.err = ERR_RANGE;
      end
      default: begin
        res.instr = base;
        res.err   = ERR_SRC;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: one-deep output register, RUN/HALT error policy, counters.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  input  logic             halt_on_err,
  input  logic             err_clr,
  output logic             halted,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  state_t   state_q;
  state_t   state_d;
  enc_res_t pack_res;
  logic     accept;
  logic     is_err;

  imm_pack u_pack (
    .base    (bus.base),
    .imm     (bus.imm),
    .imm_src (bus.imm_src),
    .res     (pack_res)
  );

  assign accept = bus.in_valid & bus.in_ready;
  assign is_err = (pack_res.err != ERR_OK);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state: halt on an accepted error when policy asks; err_clr only matters in HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (accept && is_err && halt_on_err) state_d = ST_HALT;
      ST_HALT: if (err_clr) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: accept only in RUN when the output slot is free or draining
  always_comb begin
    bus.in_ready = 1'b0;
    halted       = (state_q == ST_HALT);
    if (!rst && state_q == ST_RUN && (!bus.out_valid || bus.out_ready))
      bus.in_ready = 1'b1;
  end

  // Output register: load on accept, drop valid on drain, hold under back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_instr <= '0;
      bus.out_err   <= ERR_OK;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_instr <= pack_res.instr;
      bus.out_err   <= pack_res.err;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Accepted-request counter wraps; error counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      enc_cnt <= enc_cnt + CNT_W'(1);
      if (is_err && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed + random bench for imm_encoder with a queue-based scoreboard.
module tb_imm_encoder;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    logic [31:0] imm;
    logic [2:0]  src;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_on_err;
  logic        err_clr;
  logic        halted;
  logic [15:0] enc_cnt;
  logic [7:0]  err_cnt;
  logic        ready_ctl;
  logic        rnd_mode;
  logic        rnd_bit;

  exp_t        sb[$];
  int          pop_cyc[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_enc;
  logic [7:0]  exp_err;
  logic        bp_rec;
  logic        stall_prev;
  logic [31:0] prev_instr;
  logic [1:0]  prev_err;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(16), .ERR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .halt_on_err (halt_on_err),
    .err_clr     (err_clr),
    .halted      (halted),
    .enc_cnt     (enc_cnt),
    .err_cnt     (err_cnt)
  );

  assign bus.out_ready = rnd_mode ? rnd_bit : ready_ctl;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference packer written from the format tables, range via signed bounds
  function automatic void model(input logic [31:0] b, input logic [31:0] im, input logic [2:0] s,
                                output logic [31:0] r, output logic [1:0] e);
    int v;
    v = int'(im);
    r = b;
    e = 2'b00;
    case (s)
      3'd0: begin
        r[31:20] = im[11:0];
        if (v < -2048 || v > 2047) e = 2'b01;
      end
      3'd1: begin
        r[31:25] = im[11:5]; r[11:7] = im[4:0];
        if (v < -2048 || v > 2047) e = 2'b01;
      end
      3'd2: begin
        r[31] = im[12]; r[7] = im[11]; r[30:25] = im[10:5]; r[11:8] = im[4:1];
        if (v < -4096 || v > 4095 || im[0]) e = 2'b01;
      end
      3'd3: begin
        r[31] = im[20]; r[19:12] = im[19:12]; r[20] = im[11]; r[30:21] = im[10:1];
        if (v < -1048576 || v > 1048575 || im[0]) e = 2'b01;
      end
      3'd4: begin
        r[31:12] = im[31:12];
        if (im[11:0] != 12'h000) e = 2'b01;
      end
      default: e = 2'b10;
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] i, input logic [2:0] s);
    case (s)
      3'd0:    sext = {{20{i[31]}}, i[31:20]};
      3'd1:    sext = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    sext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    sext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4:    sext = {i[31:12], 12'h000};
      default: sext = 32'h0;
    endcase
  endfunction

  // Present one request, wait (bounded) for acceptance, record the expectation
  task automatic drive(input logic [31:0] b, input logic [31:0] im, input logic [2:0] s);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.base     = b;
    bus.imm      = im;
    bus.imm_src  = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    model(b, im, s, e.instr, e.err);
    e.imm = im;
    e.src = s;
    sb.push_back(e);
    exp_enc = exp_enc + 16'd1;
    if (e.err != 2'b00 && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    #1;
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard consumer and stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_instr", bus.out_instr, prev_instr);
        chk("hold_err", 32'(bus.out_err), 32'(prev_err));
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_instr", bus.out_instr, e.instr);
          chk("out_err", 32'(bus.out_err), 32'(e.err));
          if (e.err == 2'b00) chk("round_trip", sext(bus.out_instr, e.src), e.imm);
          if (bp_rec) pop_cyc.push_back(cyc);
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_instr = bus.out_instr;
      prev_err   = bus.out_err;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] im;
    int          v;
    logic [2:0]  s;

    rst = 1'b1; halt_on_err = 1'b0; err_clr = 1'b0; ready_ctl = 1'b1; rnd_mode = 1'b0;
    bp_rec = 1'b0; stall_prev = 1'b0; exp_enc = '0; exp_err = '0;
    bus.in_valid = 1'b0; bus.base = '0; bus.imm = '0; bus.imm_src = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed formats
    drive(32'h0000_0013, 32'hFFFF_F800, 3'd0);
    drive(32'h0000_0063, 32'h0000_0FFE, 3'd2);
    drive(32'h0000_0063, 32'h0000_0003, 3'd2);
    chk("err_cnt_b", 32'(err_cnt), 32'(exp_err));
    drive(32'h0000_0037, 32'h1234_5000, 3'd4);
    drive(32'h0000_0023, 32'hFFFF_F7FF, 3'd1);
    drive(32'h0000_006F, 32'h000F_FFFE, 3'd3);
    drive(32'h0000_006F, 32'h0010_0000, 3'd3);

    // Error with halt policy: HALT until err_clr
    halt_on_err = 1'b1;
    drive(32'h0000_0037, 32'h1234_5001, 3'd4);
    chk("halt_entered", 32'(halted), 32'd1);
    chk("halt_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_in_ready_later", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("halt_cleared", 32'(halted), 32'd0);
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);
    halt_on_err = 1'b0;

    // err_clr in RUN changes nothing
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("clr_in_run", 32'(halted), 32'd0);
    drain();

    // Back-pressure: 3 back-to-back requests behind a 4-cycle stall
    bp_rec = 1'b1;
    ready_ctl = 1'b0;
    fork
      begin
        drive(32'h0000_0013, 32'h0000_0001, 3'd0);
        drive(32'h0000_0013, 32'h0000_0002, 3'd0);
        drive(32'h0000_0013, 32'h0000_0003, 3'd0);
      end
      begin
        repeat (2) @(negedge clk);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1 ready_ctl = 1'b1;
      end
    join
    drain();
    bp_rec = 1'b0;
    chk("bp_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("bp_consec1", 32'(pop_cyc[1]), 32'(pop_cyc[0] + 1));
      chk("bp_consec2", 32'(pop_cyc[2]), 32'(pop_cyc[1] + 1));
    end

    // Illegal imm_src: base passes through, error counter saturates
    for (int k = 0; k < 300; k++) drive(32'hA5A5_5A5A ^ 32'(k), 32'(k), 3'd6);
    drain();
    chk("err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);
    chk("err_cnt_model", 32'(err_cnt), 32'(exp_err));
    chk("enc_cnt_model", 32'(enc_cnt), 32'(exp_enc));

    // Random legal round trip with random back-pressure
    rnd_mode = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      s = 3'($urandom_range(0, 4));
      case (s)
        3'd0, 3'd1: begin v = int'($urandom_range(0, 4095)) - 2048; im = 32'(v); end
        3'd2:       begin v = int'($urandom_range(0, 8191)) - 4096; im = 32'(v) & ~32'd1; end
        3'd3:       begin v = int'($urandom_range(0, 2097151)) - 1048576; im = 32'(v) & ~32'd1; end
        default:    im = $urandom & 32'hFFFF_F000;
      endcase
      drive($urandom, im, s);
    end
    drain();
    rnd_mode = 1'b0;
    chk("enc_cnt_rand", 32'(enc_cnt), 32'(exp_enc));

    // Reset with an output pending: discarded, no handshake afterwards
    ready_ctl = 1'b0;
    drive(32'h0000_0013, 32'h0000_0055, 3'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    exp_enc = '0;
    exp_err = '0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    ready_ctl = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("midrst_no_output", 32'(bus.out_valid), 32'd0);
    drive(32'h0000_0013, 32'hFFFF_F800, 3'd0);
    drain();
    chk("final_enc_cnt", 32'(enc_cnt), 32'(exp_enc));
    chk("final_err_cnt", 32'(err_cnt), 32'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
